// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central hazard sequencer for a five-stage RISC-V pipeline.
//                Drives the enable/clear pair of every segment register
//                (IF/ID, ID/EX, EX/MEM, MEM/WB), the PC hold and the two
//                EX-stage forwarding selects. Resolves load-use stalls,
//                branch/jump flushes and data-cache miss freezes. A small
//                FSM (RUN / MISS_WAIT / RESUME) owns the miss handshake.
//
//  Optional    : `define HAZARD_PERF_CNT_EN to build the StallCycles and
//                FlushCount performance counters. Without it both outputs
//                are tied to zero and no counter flops exist.
//
//  Parameters  : MISS_TIMEOUT - cycles in MISS_WAIT before MissTimeout sets
//                               (0 disables the timeout logic entirely)
//
//  Ports       : clk, rst_n              clock, async active-low reset
//                Rs1D/Rs2D               source regs of the ID instruction
//                Rs1E/Rs2E               source regs of the EX instruction
//                RdE/RdM/RdW             destination regs in EX/MEM/WB
//                RegReadE[1:0]           bit1 = rs1 used, bit0 = rs2 used
//                RegWriteE/M/W[2:0]      nonzero = stage writes Rd
//                MemToRegE               EX instruction is a load
//                BranchE, JalrE, JalD    control-flow redirects
//                DCacheMiss, DCacheReady data-cache freeze handshake
//                StallF                  PC hold
//                En*/Clr*                segment register controls
//                Forward1E/Forward2E     00 regfile, 10 MEM, 01 WB
//                MissTimeout             sticky miss-timeout flag
//                StallCycles/FlushCount  performance counters
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int unsigned MISS_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic [1:0]  RegReadE,
    input  logic [2:0]  RegWriteE,
    input  logic [2:0]  RegWriteM,
    input  logic [2:0]  RegWriteW,
    input  logic        MemToRegE,
    input  logic        BranchE,
    input  logic        JalrE,
    input  logic        JalD,
    input  logic        DCacheMiss,
    input  logic        DCacheReady,
    output logic        StallF,
    output logic        EnD,
    output logic        ClrD,
    output logic        EnE,
    output logic        ClrE,
    output logic        EnM,
    output logic        ClrM,
    output logic        EnW,
    output logic        ClrW,
    output logic [1:0]  Forward1E,
    output logic [1:0]  Forward2E,
    output logic        MissTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
);

    // ------------------------------------------------------------------------
    // Miss-handshake FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        RESUME    = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic freeze;
    logic flush_e;
    logic load_use;
    logic flush_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = RUN;
        unique case (state)
            RUN:       next_state = DCacheMiss  ? MISS_WAIT : RUN;
            MISS_WAIT: next_state = DCacheReady ? RESUME    : MISS_WAIT;
            // One extra frozen cycle so the MEM read data settles; a miss
            // request seen here is deliberately ignored.
            RESUME:    next_state = RUN;
            default:   next_state = RUN;
        endcase
    end

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    // The freeze starts combinationally in the same RUN cycle the miss is
    // raised, and covers the unused encoding until it falls back to RUN.
    assign freeze   = (state == RUN) ? DCacheMiss : 1'b1;
    assign flush_e  = BranchE | JalrE;
    assign load_use = MemToRegE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // A D-stage clear caused by a redirect (not by reset or freeze).
    assign flush_event = !freeze && (flush_e || (!load_use && JalD));

    // ------------------------------------------------------------------------
    // Segment controls. Clr is only ever raised together with its En.
    // ------------------------------------------------------------------------
    always_comb begin
        StallF = 1'b0;
        EnD    = 1'b1;
        ClrD   = 1'b0;
        EnE    = 1'b1;
        ClrE   = 1'b0;
        EnM    = 1'b1;
        ClrM   = 1'b0;
        EnW    = 1'b1;
        ClrW   = 1'b0;

        if (!rst_n) begin
            // Every segment flushes on each edge while reset is held.
            StallF = 1'b1;
            ClrD   = 1'b1;
            ClrE   = 1'b1;
            ClrM   = 1'b1;
            ClrW   = 1'b1;
        end else if (freeze) begin
            StallF = 1'b1;
            EnD    = 1'b0;
            EnE    = 1'b0;
            EnM    = 1'b0;
            EnW    = 1'b0;
        end else if (flush_e) begin
            // Redirect from EX kills both younger instructions, so any
            // load-use or JAL in ID is moot.
            ClrD   = 1'b1;
            ClrE   = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            StallF = 1'b1;
            EnD    = 1'b0;
            ClrE   = 1'b1;
        end else if (JalD) begin
            ClrD   = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // EX-stage forwarding: MEM result wins over WB result; x0 never forwards.
    // ------------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (RegWriteM != 3'd0) && (RdM != 5'd0) && (RdM == rs)) begin
            sel = 2'b10;
        end else if (used && (RegWriteW != 3'd0) && (RdW != 5'd0) && (RdW == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        Forward1E = 2'b00;
        Forward2E = 2'b00;
        if (rst_n) begin
            Forward1E = fwd_sel(RegReadE[1], Rs1E);
            Forward2E = fwd_sel(RegReadE[0], Rs2E);
        end
    end

    // ------------------------------------------------------------------------
    // Miss timeout
    // ------------------------------------------------------------------------
    logic timeout_flag;

    generate
        if (MISS_TIMEOUT != 0) begin : g_timeout
            localparam int CW = $clog2(MISS_TIMEOUT + 1);

            logic [CW-1:0] wait_cnt;

            // The counter sits at zero outside MISS_WAIT, so it is clear on
            // entry. It saturates at the limit; the flag is sticky and the
            // FSM keeps waiting regardless.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wait_cnt     <= '0;
                    timeout_flag <= 1'b0;
                end else begin
                    if (state != MISS_WAIT) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt != CW'(MISS_TIMEOUT)) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                    if ((state == MISS_WAIT) && (wait_cnt == CW'(MISS_TIMEOUT - 1))) begin
                        timeout_flag <= 1'b1;
                    end
                end
            end
        end else begin : g_no_timeout
            assign timeout_flag = 1'b0;
        end
    endgenerate

    assign MissTimeout = timeout_flag;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Both wrap naturally at 2^32. Reset holds them at zero, so the forced
    // StallF during reset is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (StallF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_event) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign StallCycles = stall_cnt;
    assign FlushCount  = flush_cnt;
`else
    assign StallCycles = 32'd0;
    assign FlushCount  = 32'd0;
`endif

    // RegWriteE is part of the EX control bundle but load-use detection
    // keys off MemToRegE alone; flush_event only feeds the counters.
    logic unused_sink;
    assign unused_sink = ^{RegWriteE, flush_event};

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl with
//                MISS_TIMEOUT = 8. Covers reset, load-use, flush priority,
//                JAL, forwarding, miss freeze/resume, timeout and reset in
//                the middle of a miss.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Packed {StallF,EnD,ClrD,EnE,ClrE,EnM,ClrM,EnW,ClrW}
    localparam logic [8:0] C_RESET  = 9'b1_1_1_1_1_1_1_1_1;
    localparam logic [8:0] C_FREEZE = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_NORMAL = 9'b0_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_FLUSHE = 9'b0_1_1_1_1_1_0_1_0;
    localparam logic [8:0] C_LDUSE  = 9'b1_0_0_1_1_1_0_1_0;
    localparam logic [8:0] C_JALD   = 9'b0_1_1_1_0_1_0_1_0;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  RegReadE;
    logic [2:0]  RegWriteE, RegWriteM, RegWriteW;
    logic        MemToRegE, BranchE, JalrE, JalD, DCacheMiss, DCacheReady;
    logic        StallF, EnD, ClrD, EnE, ClrE, EnM, ClrM, EnW, ClrW;
    logic [1:0]  Forward1E, Forward2E;
    logic        MissTimeout;
    logic [31:0] StallCycles, FlushCount;
    logic [8:0]  ctrl;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    assign ctrl = {StallF, EnD, ClrD, EnE, ClrE, EnM, ClrM, EnW, ClrW};

    pipeline_hazard_ctrl #(
        .MISS_TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegReadE   (RegReadE),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemToRegE  (MemToRegE),
        .BranchE    (BranchE),
        .JalrE      (JalrE),
        .JalD       (JalD),
        .DCacheMiss (DCacheMiss),
        .DCacheReady(DCacheReady),
        .StallF     (StallF),
        .EnD        (EnD),
        .ClrD       (ClrD),
        .EnE        (EnE),
        .ClrE       (ClrE),
        .EnM        (EnM),
        .ClrM       (ClrM),
        .EnW        (EnW),
        .ClrW       (ClrW),
        .Forward1E  (Forward1E),
        .Forward2E  (Forward2E),
        .MissTimeout(MissTimeout),
        .StallCycles(StallCycles),
        .FlushCount (FlushCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegReadE = 2'b00;
        RegWriteE = 3'd0; RegWriteM = 3'd0; RegWriteW = 3'd0;
        MemToRegE = 1'b0; BranchE = 1'b0; JalrE = 1'b0; JalD = 1'b0;
        DCacheMiss = 1'b0; DCacheReady = 1'b0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_stall"}, StallCycles, PERF ? 32'(exp_stall) : 32'd0);
        check({tag, "_flush"}, FlushCount,  PERF ? 32'(exp_flush) : 32'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        clear_inputs();
        rst_n = 1'b0;
        #3;
        check("reset_ctrl", 32'(ctrl), 32'(C_RESET));
        check("reset_timeout", 32'(MissTimeout), 32'd0);
        tick();
        tick();
        check_counters("reset_cnt");
        rst_n = 1'b1;
        #1;
        check("idle_ctrl", 32'(ctrl), 32'(C_NORMAL));
        tick();

        // ---------------- load-use on rs2 ----------------
        MemToRegE = 1'b1; RdE = 5'd5; Rs2D = 5'd5; RegWriteE = 3'd1;
        #1;
        check("lduse_ctrl", 32'(ctrl), 32'(C_LDUSE));
        tick(); exp_stall++;
        clear_inputs();
        RdM = 5'd5; RegWriteM = 3'd1; Rs2E = 5'd5; RegReadE = 2'b01;
        #1;
        check("lduse_next_ctrl", 32'(ctrl), 32'(C_NORMAL));
        check("lduse_fwd2", 32'(Forward2E), 32'(2'b10));
        check("lduse_fwd1", 32'(Forward1E), 32'(2'b00));
        tick();

        // ---------------- branch beats load-use ----------------
        clear_inputs();
        BranchE = 1'b1; MemToRegE = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
        #1;
        check("branch_ctrl", 32'(ctrl), 32'(C_FLUSHE));
        tick(); exp_flush++;

        // ---------------- JAL in ID ----------------
        clear_inputs();
        JalD = 1'b1;
        #1;
        check("jald_ctrl", 32'(ctrl), 32'(C_JALD));
        tick(); exp_flush++;
        // load-use outranks JAL in ID
        MemToRegE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
        #1;
        check("jald_lduse_ctrl", 32'(ctrl), 32'(C_LDUSE));
        tick(); exp_stall++;
        // load into x0 is not a hazard
        clear_inputs();
        MemToRegE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        check("lduse_x0_ctrl", 32'(ctrl), 32'(C_NORMAL));
        tick();
        clear_inputs();
        JalrE = 1'b1; JalD = 1'b1;
        #1;
        check("jalr_ctrl", 32'(ctrl), 32'(C_FLUSHE));
        tick(); exp_flush++;
        clear_inputs();
        #1;
        check_counters("hazard_cnt");

        // ---------------- forwarding ----------------
        RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; RegWriteM = 3'd1; RegWriteW = 3'd2;
        RegReadE = 2'b10;
        #1;
        check("fwd1_mem", 32'(Forward1E), 32'(2'b10));
        RdM = 5'd0;
        #1;
        check("fwd1_wb", 32'(Forward1E), 32'(2'b01));
        RdW = 5'd0; Rs1E = 5'd0;
        #1;
        check("fwd1_x0", 32'(Forward1E), 32'(2'b00));
        RdM = 5'd7; Rs1E = 5'd7; RegReadE = 2'b00;
        #1;
        check("fwd1_unused", 32'(Forward1E), 32'(2'b00));
        RdM = 5'd0; RdW = 5'd12; Rs2E = 5'd12; RegReadE = 2'b01;
        #1;
        check("fwd2_wb", 32'(Forward2E), 32'(2'b01));
        RegWriteW = 3'd0;
        #1;
        check("fwd2_nowrite", 32'(Forward2E), 32'(2'b00));
        tick();

        // ---------------- miss: 4 cycles then ready ----------------
        clear_inputs();
        DCacheMiss = 1'b1; BranchE = 1'b1;   // freeze overrides the branch
        #1;
        check("miss_run_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick(); exp_stall++;
        BranchE = 1'b0;
        #1;
        check("miss_wait1_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick(); exp_stall++;
        tick(); exp_stall++;
        DCacheReady = 1'b1;
        #1;
        check("miss_wait3_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick(); exp_stall++;
        DCacheReady = 1'b0;                  // DCacheMiss still 1: ignored
        #1;
        check("resume_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick(); exp_stall++;
        DCacheMiss = 1'b0;
        #1;
        check("after_miss_ctrl", 32'(ctrl), 32'(C_NORMAL));
        check("after_miss_timeout", 32'(MissTimeout), 32'd0);
        check_counters("miss_cnt");
        tick();

        // ---------------- timeout ----------------
        DCacheMiss = 1'b1;
        #1;
        tick(); exp_stall++;
        DCacheMiss = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(); exp_stall++;
        end
        check("timeout_before", 32'(MissTimeout), 32'd0);
        check("timeout_before_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick(); exp_stall++;
        check("timeout_set", 32'(MissTimeout), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); exp_stall++;
        end
        check("timeout_sticky", 32'(MissTimeout), 32'd1);
        check("timeout_freeze_ctrl", 32'(ctrl), 32'(C_FREEZE));
        check_counters("timeout_cnt");

        // ---------------- reset in the middle of MISS_WAIT ----------------
        RdM = 5'd7; Rs1E = 5'd7; RegWriteM = 3'd1; RegReadE = 2'b11;
        Rs2E = 5'd7;
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("midreset_ctrl", 32'(ctrl), 32'(C_RESET));
        check("midreset_timeout", 32'(MissTimeout), 32'd0);
        check("midreset_fwd", 32'({Forward1E, Forward2E}), 32'd0);
        check_counters("midreset_cnt");
        #1;
        rst_n = 1'b1;
        clear_inputs();
        #1;
        check("postreset_ctrl", 32'(ctrl), 32'(C_NORMAL));
        tick();
        check("postreset_run_ctrl", 32'(ctrl), 32'(C_NORMAL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
